// File: rtl/md_hazard_ctrl.sv
// Hazard controller: data-hazard stall detection against E/M producers,
// mult/div busy tracking, and a saturating stall-cycle counter.
module md_hazard_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  rs_d,
  input  logic [4:0]  rt_d,
  input  logic [1:0]  tuse_rs,
  input  logic [1:0]  tuse_rt,
  input  logic [4:0]  a3_e,
  input  logic [4:0]  a3_m,
  input  logic [1:0]  tnew_e,
  input  logic [1:0]  tnew_m,
  input  logic        md_use_d,
  input  logic        md_start_e,
  input  logic        md_div_e,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        idex_clr,
  output logic        md_busy,
  output logic [3:0]  md_cnt,
  output logic [31:0] stall_cnt
);

  localparam int unsigned CNT_W   = 4;
  localparam int unsigned STALL_W = 32;

  localparam logic [CNT_W-1:0] MULT_CYCLES = CNT_W'(5);
  localparam logic [CNT_W-1:0] DIV_CYCLES  = CNT_W'(10);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic stall_rs, stall_rt, stall_md, stall;

  // Same-cycle stall decision from D-stage needs vs E/M producer readiness
  always_comb begin
    stall_rs = 1'b0;
    stall_rt = 1'b0;
    stall_md = 1'b0;
    stall_rs = (rs_d != 5'd0) &
               (((rs_d == a3_e) & (tnew_e > tuse_rs)) |
                ((rs_d == a3_m) & (tnew_m > tuse_rs)));
    stall_rt = (rt_d != 5'd0) &
               (((rt_d == a3_e) & (tnew_e > tuse_rt)) |
                ((rt_d == a3_m) & (tnew_m > tuse_rt)));
    stall_md = md_use_d & (md_busy | md_start_e);
  end

  assign stall    = stall_rs | stall_rt | stall_md;
  assign pc_en    = ~stall;
  assign ifid_en  = ~stall;
  assign idex_clr = stall;

  assign md_busy  = (state_q == BUSY);
  assign md_cnt   = cnt_q;

  // Busy-tracker state and countdown registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: load on start from IDLE, count down in BUSY, starts in BUSY ignored
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (md_start_e) begin
          state_d = BUSY;
          cnt_d   = md_div_e ? DIV_CYCLES : MULT_CYCLES;
        end
      end
      BUSY: begin
        if (cnt_q <= CNT_W'(1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Saturating count of stalled cycles
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != {STALL_W{1'b1}})) begin
      stall_cnt <= stall_cnt + STALL_W'(1);
    end
  end

endmodule

// File: tb/tb_md_hazard_ctrl.sv
// Self-checking bench for md_hazard_ctrl: cycle model plus directed literal checks.
module tb_md_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  rs_d, rt_d, a3_e, a3_m;
  logic [1:0]  tuse_rs, tuse_rt, tnew_e, tnew_m;
  logic        md_use_d, md_start_e, md_div_e;
  logic        pc_en, ifid_en, idex_clr, md_busy;
  logic [3:0]  md_cnt;
  logic [31:0] stall_cnt;

  int checks   = 0;
  int failures = 0;

  md_hazard_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .rs_d       (rs_d),
    .rt_d       (rt_d),
    .tuse_rs    (tuse_rs),
    .tuse_rt    (tuse_rt),
    .a3_e       (a3_e),
    .a3_m       (a3_m),
    .tnew_e     (tnew_e),
    .tnew_m     (tnew_m),
    .md_use_d   (md_use_d),
    .md_start_e (md_start_e),
    .md_div_e   (md_div_e),
    .pc_en      (pc_en),
    .ifid_en    (ifid_en),
    .idex_clr   (idex_clr),
    .md_busy    (md_busy),
    .md_cnt     (md_cnt),
    .stall_cnt  (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: remaining busy cycles as a plain integer, stall count as an integer
  int unsigned m_rem    = 0;
  logic [31:0] m_stalls = 0;
  bit          m_valid  = 0;

  function automatic bit model_stall();
    int src[2];
    int need[2];
    int dst[2];
    int ready[2];
    src   = '{int'(rs_d), int'(rt_d)};
    need  = '{int'(tuse_rs), int'(tuse_rt)};
    dst   = '{int'(a3_e), int'(a3_m)};
    ready = '{int'(tnew_e), int'(tnew_m)};
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++)
        if (src[i] != 0 && src[i] == dst[j] && ready[j] > need[i]) return 1'b1;
    if (md_use_d && (m_rem != 0 || md_start_e)) return 1'b1;
    return 1'b0;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_rem    = 0;
      m_stalls = 0;
      m_valid  = 1'b1;
    end else begin
      if (model_stall() && m_stalls != 32'hFFFF_FFFF) m_stalls = m_stalls + 32'd1;
      if (m_rem != 0) m_rem = m_rem - 1;
      else if (md_start_e) m_rem = md_div_e ? 10 : 5;
    end
  end

  // Compare DUT against model every cycle, away from the active edge
  always @(negedge clk) begin
    if (m_valid) begin
      bit s;
      s = model_stall();
      chk("pc_en",     32'(pc_en),    32'(!s));
      chk("ifid_en",   32'(ifid_en),  32'(!s));
      chk("idex_clr",  32'(idex_clr), 32'(s));
      chk("md_busy",   32'(md_busy),  32'(m_rem != 0));
      chk("md_cnt",    32'(md_cnt),   m_rem);
      chk("stall_cnt", stall_cnt,     m_stalls);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    rs_d = 0; rt_d = 0; a3_e = 0; a3_m = 0;
    tuse_rs = 0; tuse_rt = 0; tnew_e = 0; tnew_m = 0;
    md_use_d = 0; md_start_e = 0; md_div_e = 0;
  endtask

  // One data-hazard vector held for one cycle with its hand-computed stall
  task automatic hz(input string name, input logic [4:0] rs, input logic [1:0] urs,
                    input logic [4:0] rt, input logic [1:0] urt,
                    input logic [4:0] ae, input logic [1:0] ne,
                    input logic [4:0] am, input logic [1:0] nm, input bit exp);
    clear_in();
    rs_d = rs; tuse_rs = urs; rt_d = rt; tuse_rt = urt;
    a3_e = ae; tnew_e = ne; a3_m = am; tnew_m = nm;
    #1;
    chk({name, "_pc_en"},    32'(pc_en),    32'(!exp));
    chk({name, "_ifid_en"},  32'(ifid_en),  32'(!exp));
    chk({name, "_idex_clr"}, 32'(idex_clr), 32'(exp));
    cyc();
  endtask

  initial begin
    clear_in();
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
    #1;
    chk("rst_busy",     32'(md_busy),  32'd0);
    chk("rst_cnt",      32'(md_cnt),   32'd0);
    chk("rst_stallcnt", stall_cnt,     32'd0);
    chk("rst_pc_en",    32'(pc_en),    32'd1);
    chk("rst_ifid_en",  32'(ifid_en),  32'd1);
    chk("rst_idex_clr", 32'(idex_clr), 32'd0);

    // Load-use on rs from E: stall this cycle, counter +1 after the edge
    hz("lw_use",   5'd1, 2'd1, 5'd0, 2'd0, 5'd1, 2'd2, 5'd0, 2'd0, 1'b1);
    chk("lw_use_stallcnt", stall_cnt, 32'd1);
    hz("r0",       5'd0, 2'd0, 5'd0, 2'd0, 5'd0, 2'd2, 5'd0, 2'd0, 1'b0);
    hz("e_gt",     5'd3, 2'd0, 5'd0, 2'd0, 5'd3, 2'd1, 5'd0, 2'd0, 1'b1);
    hz("e_eq",     5'd3, 2'd1, 5'd0, 2'd0, 5'd3, 2'd1, 5'd0, 2'd0, 1'b0);
    hz("m_rt",     5'd0, 2'd0, 5'd7, 2'd0, 5'd0, 2'd0, 5'd7, 2'd1, 1'b1);
    hz("tuse3",    5'd0, 2'd0, 5'd7, 2'd3, 5'd0, 2'd0, 5'd7, 2'd2, 1'b0);
    hz("tnew0",    5'd9, 2'd0, 5'd0, 2'd0, 5'd9, 2'd0, 5'd0, 2'd0, 1'b0);
    hz("diff_reg", 5'd4, 2'd0, 5'd0, 2'd0, 5'd5, 2'd2, 5'd0, 2'd0, 1'b0);
    hz("m_rs31",   5'd31, 2'd1, 5'd0, 2'd0, 5'd0, 2'd0, 5'd31, 2'd2, 1'b1);
    chk("vec_stallcnt", stall_cnt, 32'd4);

    // Div start with md_use_d held: start cycle plus 10 busy cycles stall
    clear_in();
    md_start_e = 1; md_div_e = 1; md_use_d = 1;
    #1;
    chk("div_start_stall", 32'(idex_clr), 32'd1);
    cyc();
    md_start_e = 0; md_div_e = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("div_busy",  32'(md_busy),  32'd1);
      chk("div_cnt",   32'(md_cnt),   32'(10 - i));
      chk("div_stall", 32'(idex_clr), 32'd1);
      cyc();
    end
    #1;
    chk("div_done_busy",  32'(md_busy),  32'd0);
    chk("div_done_cnt",   32'(md_cnt),   32'd0);
    chk("div_done_pc_en", 32'(pc_en),    32'd1);
    chk("div_stallcnt",   stall_cnt,     32'd15);

    // Mult with a second start at md_cnt = 3: no reload
    clear_in();
    md_start_e = 1;
    cyc();
    md_start_e = 0;
    cyc();
    cyc();
    chk("mult_cnt3", 32'(md_cnt), 32'd3);
    md_start_e = 1;
    cyc();
    md_start_e = 0;
    chk("mult_noreload", 32'(md_cnt), 32'd2);
    cyc();
    chk("mult_cnt1", 32'(md_cnt), 32'd1);
    cyc();
    chk("mult_done_busy", 32'(md_busy), 32'd0);
    chk("mult_done_cnt",  32'(md_cnt),  32'd0);

    // Mixed patterns checked by the model only
    for (int i = 0; i < 80; i++) begin
      rs_d = 5'($urandom_range(0, 3)); rt_d = 5'($urandom_range(0, 3));
      a3_e = 5'($urandom_range(0, 3)); a3_m = 5'($urandom_range(0, 3));
      tuse_rs = 2'($urandom_range(0, 3)); tuse_rt = 2'($urandom_range(0, 3));
      tnew_e = 2'($urandom_range(0, 2)); tnew_m = 2'($urandom_range(0, 2));
      md_use_d = 1'($urandom_range(0, 1));
      md_start_e = ($urandom_range(0, 5) == 0);
      md_div_e = 1'($urandom_range(0, 1));
      cyc();
    end
    clear_in();
    repeat (12) cyc();

    // Reset mid-div at md_cnt = 6, with a start on the reset edge
    md_start_e = 1; md_div_e = 1;
    cyc();
    md_start_e = 0; md_div_e = 0;
    repeat (4) cyc();
    chk("rst_mid_cnt6", 32'(md_cnt), 32'd6);
    md_use_d = 1; md_start_e = 1; md_div_e = 1; reset = 1;
    cyc();
    reset = 0; md_start_e = 0; md_div_e = 0;
    #1;
    chk("rst_mid_busy",     32'(md_busy),  32'd0);
    chk("rst_mid_cnt",      32'(md_cnt),   32'd0);
    chk("rst_mid_stallcnt", stall_cnt,     32'd0);
    chk("rst_mid_idex_clr", 32'(idex_clr), 32'd0);
    chk("rst_mid_pc_en",    32'(pc_en),    32'd1);
    cyc();
    clear_in();
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
